// File: rtl/pipe_mult_fu_if.sv
// Issue/completion bundle for the pipelined multiply unit.
// master = RS issue logic plus CDB selector; slave = the multiply unit.
interface pipe_mult_fu_if #(
  parameter int XLEN   = 32,
  parameter int ROBN_W = 5,
  parameter int PRN_W  = 6
);
  logic              start;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [1:0]        func;
  logic [ROBN_W-1:0] robn;
  logic [PRN_W-1:0]  dest_prn;
  logic              squash;
  logic              avail;
  logic              ready;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [ROBN_W-1:0] out_robn;
  logic [PRN_W-1:0]  out_dest_prn;

  modport master (
    output start, rs1, rs2, func, robn, dest_prn, squash, avail,
    input  ready, done, result, out_robn, out_dest_prn
  );

  modport slave (
    input  start, rs1, rs2, func, robn, dest_prn, squash, avail,
    output ready, done, result, out_robn, out_dest_prn
  );
endinterface

// File: rtl/pipe_mult_fu.sv
// Bubble-collapsing pipelined integer multiplier (MUL/MULH/MULHSU/MULHU).
// Each stage carries its own ROB and physical-register tags.
module pipe_mult_fu #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int ROBN_W     = 5,
  parameter int PRN_W      = 6
) (
  input  logic           clock,
  input  logic           reset,
  pipe_mult_fu_if.slave  bus
);
  localparam int CW = XLEN / NUM_STAGES;
  localparam int PW = 2 * XLEN;

  localparam logic [1:0] FN_MUL   = 2'b00;
  localparam logic [1:0] FN_MULHU = 2'b11;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] load;
  logic                  ready;
  logic                  accept;

  logic [PW-1:0]     acc_q    [NUM_STAGES];
  logic [PW-1:0]     mcand_q  [NUM_STAGES];
  logic [PW-1:0]     mplier_q [NUM_STAGES];
  logic [1:0]        func_q   [NUM_STAGES];
  logic [ROBN_W-1:0] robn_q   [NUM_STAGES];
  logic [PRN_W-1:0]  prn_q    [NUM_STAGES];
  logic [XLEN-1:0]   result_q;

  logic [PW-1:0]     src_acc  [NUM_STAGES];
  logic [PW-1:0]     src_mc   [NUM_STAGES];
  logic [PW-1:0]     src_mp   [NUM_STAGES];
  logic [1:0]        src_func [NUM_STAGES];
  logic [ROBN_W-1:0] src_robn [NUM_STAGES];
  logic [PRN_W-1:0]  src_prn  [NUM_STAGES];
  logic [PW-1:0]     nxt_acc  [NUM_STAGES];

  logic [PW-1:0] mcand_in;
  logic [PW-1:0] mplier_in;

  assign mcand_in  = (bus.func == FN_MULHU) ? {{XLEN{1'b0}}, bus.rs1}
                                            : {{XLEN{bus.rs1[XLEN-1]}}, bus.rs1};
  assign mplier_in = bus.func[1] ? {{XLEN{1'b0}}, bus.rs2}
                                 : {{XLEN{bus.rs2[XLEN-1]}}, bus.rs2};

  // Advance resolves from the output end back toward stage 0 so a stalled
  // head only blocks the stages packed directly behind it.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = valid_q[NUM_STAGES-1] && bus.avail;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      adv[NUM_STAGES-1-i] = valid_q[NUM_STAGES-1-i] &&
                            (!valid_q[NUM_STAGES-i] || adv[NUM_STAGES-i]);
    end
  end

  assign ready  = !valid_q[0] || adv[0];
  assign accept = bus.start && ready && !bus.squash;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      load[i] = adv[i-1];
    end
  end

  // Stage k folds in multiplier chunk k and its partner chunk k+NUM_STAGES
  // from the upper (extension) half, so the 2*XLEN product is exact.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = (k + NUM_STAGES) * CW;

    if (k == 0) begin : g_head
      assign src_acc[k]  = '0;
      assign src_mc[k]   = mcand_in;
      assign src_mp[k]   = mplier_in;
      assign src_func[k] = bus.func;
      assign src_robn[k] = bus.robn;
      assign src_prn[k]  = bus.dest_prn;
    end else begin : g_body
      assign src_acc[k]  = acc_q[k-1];
      assign src_mc[k]   = mcand_q[k-1];
      assign src_mp[k]   = mplier_q[k-1];
      assign src_func[k] = func_q[k-1];
      assign src_robn[k] = robn_q[k-1];
      assign src_prn[k]  = prn_q[k-1];
    end

    assign nxt_acc[k] = src_acc[k]
                      + ((src_mc[k] * PW'(src_mp[k][LO +: CW])) << LO)
                      + ((src_mc[k] * PW'(src_mp[k][HI +: CW])) << HI);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      result_q <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        acc_q[i]    <= '0;
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
        func_q[i]   <= '0;
        robn_q[i]   <= '0;
        prn_q[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (bus.squash)   valid_q[i] <= 1'b0;
        else if (load[i]) valid_q[i] <= 1'b1;
        else if (adv[i])  valid_q[i] <= 1'b0;

        if (load[i]) begin
          acc_q[i]    <= nxt_acc[i];
          mcand_q[i]  <= src_mc[i];
          mplier_q[i] <= src_mp[i];
          func_q[i]   <= src_func[i];
          robn_q[i]   <= src_robn[i];
          prn_q[i]    <= src_prn[i];
        end
      end
      if (load[NUM_STAGES-1]) begin
        result_q <= (src_func[NUM_STAGES-1] == FN_MUL)
                    ? nxt_acc[NUM_STAGES-1][XLEN-1:0]
                    : nxt_acc[NUM_STAGES-1][PW-1:XLEN];
      end
    end
  end

  assign bus.ready        = ready;
  assign bus.done         = valid_q[NUM_STAGES-1];
  assign bus.result       = result_q;
  assign bus.out_robn     = robn_q[NUM_STAGES-1];
  assign bus.out_dest_prn = prn_q[NUM_STAGES-1];
endmodule

// File: tb/tb_pipe_mult_fu.sv
// Self-checking bench for pipe_mult_fu: directed scenarios plus random traffic
// scored against a queue-based model of an in-order, stall-collapsing pipe.
module tb_pipe_mult_fu;
  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int RW   = 5;
  localparam int PRW  = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipe_mult_fu_if #(.XLEN(XLEN), .ROBN_W(RW), .PRN_W(PRW)) bus ();

  pipe_mult_fu #(.XLEN(XLEN), .NUM_STAGES(N), .ROBN_W(RW), .PRN_W(PRW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  robn;
    logic [5:0]  prn;
    int          t;
  } ent_t;

  ent_t q[$];
  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int last_cons = -100;

  function automatic logic [31:0] ref_mul(logic [1:0] fn, logic [31:0] a, logic [31:0] b);
    logic [63:0] x, y, p;
    x = (fn == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
    y = fn[1] ? {32'h0, b} : {{32{b[31]}}, b};
    p = x * y;
    return (fn == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against the model, update the model, advance.
  task automatic cyc_step(input logic st, input logic [1:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rb, input logic [5:0] pr,
                          input logic sq, input logic av);
    bit exp_done, exp_ready;
    int due;
    bus.start = st; bus.func = fn; bus.rs1 = a; bus.rs2 = b;
    bus.robn = rb; bus.dest_prn = pr; bus.squash = sq; bus.avail = av;
    #1;
    exp_done = 1'b0;
    if (q.size() > 0) begin
      due = (q[0].t + N > last_cons + 1) ? q[0].t + N : last_cons + 1;
      exp_done = (cyc >= due);
    end
    exp_ready = (q.size() < N) || av;
    chk("ready", bus.ready, exp_ready);
    chk("done", bus.done, exp_done);
    if (exp_done) begin
      chk("result", bus.result, q[0].res);
      chk("out_robn", bus.out_robn, q[0].robn);
      chk("out_dest_prn", bus.out_dest_prn, q[0].prn);
      if (av) begin
        last_cons = cyc;
        void'(q.pop_front());
      end
    end
    if (sq) q.delete();
    else if (st && exp_ready) q.push_back('{ref_mul(fn, a, b), rb, pr, cyc});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic av);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, av);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    bus.start = 1'b0; bus.func = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.robn = '0; bus.dest_prn = '0; bus.squash = 1'b0; bus.avail = 1'b0;

    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_robn", bus.out_robn, 5'h0);
    chk("rst_prn", bus.out_dest_prn, 6'h0);
    chk("rst_ready", bus.ready, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc++;

    // Single MUL with negative multiplier; result exactly N cycles after accept
    cyc_step(1'b1, 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3, 6'd17, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("lat_done", bus.done, 1'b1);
    chk("lat_result", bus.result, 32'hFFFF_FFEB);
    chk("lat_robn", bus.out_robn, 5'd3);
    chk("lat_prn", bus.out_dest_prn, 6'd17);
    idle(2, 1'b1);

    // One of each function, back to back
    cyc_step(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 6'd1, 1'b0, 1'b1);
    cyc_step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 6'd2, 1'b0, 1'b1);
    cyc_step(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 6'd3, 1'b0, 1'b1);
    cyc_step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 6'd4, 1'b0, 1'b1);
    chk("mulh", bus.result, 32'h4000_0000);
    idle(1, 1'b1);
    chk("mulhu", bus.result, 32'hFFFF_FFFE);
    idle(1, 1'b1);
    chk("mulhsu", bus.result, 32'hFFFF_FFFF);
    idle(1, 1'b1);
    chk("mul_m1", bus.result, 32'h0000_0001);
    idle(2, 1'b1);

    // Eight back-to-back issues at full throughput
    for (int i = 0; i < 8; i++)
      cyc_step(1'b1, 2'($urandom), rand_opnd(), rand_opnd(), 5'(i), 6'(i + 20), 1'b0, 1'b1);
    idle(6, 1'b1);

    // Stall with a gap that must collapse, then fill until ready drops
    cyc_step(1'b1, 2'b00, 32'd11, 32'd13, 5'd10, 6'd40, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc_step(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11, 6'd41, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc_step(1'b1, 2'b10, 32'hCAFE_F00D, 32'h8765_4321, 5'd12, 6'd42, 1'b0, 1'b0);
    cyc_step(1'b1, 2'b11, 32'h0BAD_CAFE, 32'hFEED_FACE, 5'd13, 6'd43, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full_ready", bus.ready, 1'b0);
    cyc_step(1'b1, 2'b00, 32'd99, 32'd99, 5'd14, 6'd44, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Squash with a same-cycle start
    for (int i = 0; i < 3; i++)
      cyc_step(1'b1, 2'b00, rand_opnd(), rand_opnd(), 5'(i + 16), 6'(i), 1'b0, 1'b1);
    cyc_step(1'b1, 2'b00, 32'd3, 32'd3, 5'd31, 6'd63, 1'b1, 1'b1);
    chk("sq_done", bus.done, 1'b0);
    chk("sq_ready", bus.ready, 1'b1);
    idle(6, 1'b1);

    // Asynchronous reset between edges with a full pipe
    for (int i = 0; i < 4; i++)
      cyc_step(1'b1, 2'b00, rand_opnd(), rand_opnd(), 5'(i + 24), 6'(i + 8), 1'b0, 1'b0);
    bus.start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_done", bus.done, 1'b0);
    chk("arst_result", bus.result, 32'h0);
    chk("arst_ready", bus.ready, 1'b1);
    q.delete();
    last_cons = -100;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
    cyc_step(1'b1, 2'b00, 32'd5, 32'd6, 5'd7, 6'd9, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("post_rst_done", bus.done, 1'b1);
    chk("post_rst_result", bus.result, 32'd30);
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc_step($urandom_range(0, 9) < 7, 2'($urandom), rand_opnd(), rand_opnd(),
               5'($urandom), 6'($urandom), $urandom_range(0, 99) < 3,
               $urandom_range(0, 9) < 6);
    idle(10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_mult_fu.md
Name: pipe_mult_fu

Overview:
Parametrised, fully pipelined integer multiply functional unit. It replaces the single-instance mult wrapper with a bubble-collapsing pipeline that can hold up to NUM_STAGES multiplies in flight. Each slot carries its own robn and dest_prn tag. The unit has a ready/avail handshake on both ends and a squash input for branch recovery. It sits between the RS issue logic and the CDB priority selector, one instance per mult FU slot.

Parameters:
XLEN, 32, operand and result width in bits
NUM_STAGES, 4, pipeline depth; each stage consumes XLEN/NUM_STAGES multiplier bits; XLEN % NUM_STAGES must equal 0; NUM_STAGES >= 1
ROBN_W, 5, width of ROB tag
PRN_W, 6, width of physical register tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  issue request; valid operands present this cycle
rs1  in  XLEN  multiplicand operand (already muxed)
rs2  in  XLEN  multiplier operand (already muxed)
func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
robn  in  ROBN_W  ROB tag of issuing instruction
dest_prn  in  PRN_W  destination physical register
squash  in  1  synchronous flush of all in-flight work
avail  in  1  downstream (CDB selector) accepts the output this cycle
ready  out  1  unit accepts start this cycle
done  out  1  result, out_robn and out_dest_prn are valid
result  out  XLEN  multiply result
out_robn  out  ROBN_W  tag of completing instruction
out_dest_prn  out  PRN_W  destination of completing instruction

Behaviour:
- Reset (async, active-high): all stage valid bits, accumulators, multiplicands, tags and func registers clear to 0. Outputs go to done=0, result=0, out_robn=0, out_dest_prn=0, ready=1. Reset asserted mid-operation discards all in-flight work immediately.
- Operand extension at accept: both operands are extended to 2*XLEN.
  - MUL, MULH: rs1 and rs2 are sign-extended.
  - MULHSU: rs1 is sign-extended; rs2 is zero-extended.
  - MULHU: both are zero-extended.
- Arithmetic: all arithmetic is mod 2^(2*XLEN).
  - Stage k adds (multiplicand * multiplier chunk k) << (k*XLEN/NUM_STAGES) to the accumulator.
  - The chunk is unsigned XLEN/NUM_STAGES bits taken from the extended multiplier. The high half of the extended multiplier is consumed as well, so the full 2*XLEN product is exact.
  - An acceptable alternative: feed NUM_STAGES*2 chunks, or fold the upper extension as a correction term. The required output is the exact low 2*XLEN bits of the product.
- Chunk 0 is computed combinationally before the stage-0 register.
- Result select at the last stage: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Advance rules:
  - adv[N-1] = valid[N-1] && avail.
  - adv[k] = valid[k] && (!valid[k+1] || adv[k+1]).
- Accept rules:
  - ready = !valid[0] || adv[0] (combinational).
  - Accept = start && ready && !squash; accepted data loads stage 0 at the next edge.
  - start while ready=0 is ignored; RS must hold and retry.
- Latency: accept in cycle t, with no stalls, gives done=1 in cycle t+NUM_STAGES. Throughput is 1 per cycle while avail=1.
- Output hold: done=valid[N-1]. While done=1 && avail=0, result and tags stay stable and do not change. Upstream stages keep advancing into empty slots (bubbles collapse) until the pipeline is full; then ready=0.
- avail with done=0 has no effect.
- Squash: at the next edge all valid bits clear. A start in the same cycle is dropped. done is 0 from the following cycle.
- Squash and avail together: the current output counts as consumed by the CDB this cycle (the selector sees done=1); the squash still clears it.
- Tags and func travel with their stage unchanged.
- Outputs are registered except ready.

Test Plan:
- MUL 7 * 0xFFFFFFFD, avail=1 -> done=1 exactly 4 cycles after accept, result=0xFFFFFFEB, out_robn/out_dest_prn equal the issued tags (robn=3, prn=17).
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- 8 back-to-back starts with distinct robn 0..7, avail=1 -> ready stays 1, done high 8 consecutive cycles starting cycle 4, results and tags in issue order.
- Issue 2 ops 2 cycles apart, hold avail=0 -> done=1 with first result stable, gap collapses. Keep issuing -> ready drops after the 4th op is held in the pipeline. Raise avail -> the 4 results drain in order, one per cycle.
- 3 ops in flight, assert squash together with a new start -> next cycle all valid bits are 0, done=0, ready=1; the dropped start never appears at the output.
- Assert reset asynchronously between clock edges with 4 ops in flight -> done=0, result=0, ready=1 immediately without an edge. After release, a new MUL 5*6 yields 30 after 4 cycles.
